// File: rtl/sv_timer_pkg.sv
// rtl/sv_timer_pkg.sv - register map, control layout and shared types for sv_irq_timer
package sv_timer_pkg;

  localparam logic [3:0] OFS_COUNT  = 4'h0;
  localparam logic [3:0] OFS_CTRL   = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_MASK   = 4'h9;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PSEL = 2;
  localparam int CTRL_AUTO = 3;

  localparam int PRE_W = 14;

  typedef struct packed {
    logic auto;
    logic psel;
    logic ie;
    logic en;
  } ctrl_t;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/sv_irq_timer_if.sv
// rtl/sv_irq_timer_if.sv - CPU register bus between the 65C02 window and sv_irq_timer
interface sv_irq_timer_if;
  logic       cs;
  logic       we;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output cs, output we, output addr, output din, input dout);
  modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/sv_timer_channel.sv
// rtl/sv_timer_channel.sv - one down-counter channel with reload, prescaler select and expiry pulse
module sv_timer_channel
  import sv_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_ld_val,
  input  logic             i_ctrl_wr,
  input  ctrl_t            i_ctrl_val,
  input  logic             i_tick_short,
  input  logic             i_tick_long,
  output logic [CNT_W-1:0] o_count,
  output ctrl_t            o_ctrl,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_reload;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_tick;
  ch_state_t        w_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_reload <= '0;
      r_ctrl   <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (i_load)    r_reload <= i_ld_val;
      if (i_ctrl_wr) r_ctrl   <= i_ctrl_val;
    end
  end

  // A bus load always wins over a decrement landing on the same edge.
  always_comb begin
    w_state     = (r_ctrl.en && (r_count != '0)) ? CH_RUN : CH_IDLE;
    w_tick      = r_ctrl.psel ? i_tick_long : i_tick_short;
    w_count_nxt = r_count;
    o_expire    = 1'b0;
    if (i_load) begin
      w_count_nxt = i_ld_val;
      o_expire    = r_ctrl.en && (i_ld_val == '0);
    end else if ((w_state == CH_RUN) && w_tick) begin
      if (r_count == CNT_W'(1)) begin
        o_expire    = 1'b1;
        w_count_nxt = r_ctrl.auto ? r_reload : '0;
      end else begin
        w_count_nxt = r_count - CNT_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/sv_irq_timer.sv
// rtl/sv_irq_timer.sv - multi-channel interval timer and IRQ aggregator for the 0x2020 window
// Optional macro SV_TIMER_READ_ACK_EN: a STATUS read also clears the bits it returned.
module sv_irq_timer
  import sv_timer_pkg::*;
#(
  parameter int NUM_TIMERS = 2,
  parameter int CNT_W      = 8,
  parameter int EXT_IRQS   = 2,
  parameter int PRE_SHORT  = 256,
  parameter int PRE_LONG   = 16384
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     ce_tick,
  sv_irq_timer_if.slave                            bus,
  input  logic [((EXT_IRQS > 0) ? EXT_IRQS : 1)-1:0] ext_irq,
  output logic                                     irq,
  output logic                                     tick_short
);

  localparam int EXT_W = (EXT_IRQS > 0) ? EXT_IRQS : 1;
  localparam int SH_W  = $clog2(PRE_SHORT);
  localparam int LG_W  = $clog2(PRE_LONG);

  logic [PRE_W-1:0]  r_pre;
  logic [EXT_W-1:0]  r_ext_q;
  logic [7:0]        r_status;
  logic [7:0]        r_mask;
  logic [7:0]        r_dout;
  logic              r_irq;

  logic              w_wr, w_rd;
  logic              w_tick_short, w_tick_long;
  logic [EXT_W-1:0]  w_ext_edge;
  logic [CNT_W-1:0]  w_count [NUM_TIMERS];
  ctrl_t             w_ctrl  [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] w_expire;
  logic [7:0]        w_set, w_clr, w_ie, w_valid, w_status_nxt, w_rdata;

  assign w_wr         = bus.cs & bus.we;
  assign w_rd         = bus.cs & ~bus.we;
  assign w_tick_short = ce_tick & (&r_pre[SH_W-1:0]);
  assign w_tick_long  = ce_tick & (&r_pre[LG_W-1:0]);
  assign w_ext_edge   = ext_irq & ~r_ext_q;

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    sv_timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_wr && (bus.addr == (OFS_COUNT + 4'(g)))),
      .i_ld_val     (bus.din[CNT_W-1:0]),
      .i_ctrl_wr    (w_wr && (bus.addr == (OFS_CTRL + 4'(g)))),
      .i_ctrl_val   (ctrl_t'(bus.din[3:0])),
      .i_tick_short (w_tick_short),
      .i_tick_long  (w_tick_long),
      .o_count      (w_count[g]),
      .o_ctrl       (w_ctrl[g]),
      .o_expire     (w_expire[g])
    );
  end

  // Set terms are OR-ed in after the clear so a same-cycle event is never lost.
  always_comb begin
    w_set   = '0;
    w_ie    = '0;
    w_valid = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      w_set[i]   = w_expire[i];
      w_ie[i]    = w_ctrl[i].ie;
      w_valid[i] = 1'b1;
    end
    for (int j = 0; j < EXT_IRQS; j++) begin
      w_set[4+j]   = w_ext_edge[j];
      w_valid[4+j] = 1'b1;
    end
    w_clr = (w_wr && (bus.addr == OFS_STATUS)) ? (bus.din & w_valid) : 8'h00;
`ifdef SV_TIMER_READ_ACK_EN
    if (w_rd && (bus.addr == OFS_STATUS)) w_clr = w_clr | r_status;
`endif
    w_status_nxt = (r_status & ~w_clr) | w_set;
  end

  always_comb begin
    w_rdata = 8'hFF;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (bus.addr == (OFS_COUNT + 4'(i))) w_rdata = 8'(w_count[i]);
      if (bus.addr == (OFS_CTRL + 4'(i)))  w_rdata = {4'b0000, w_ctrl[i]};
    end
    if (bus.addr == OFS_STATUS) w_rdata = r_status;
    if (bus.addr == OFS_MASK)   w_rdata = r_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre    <= '0;
      r_ext_q  <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_dout   <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (ce_tick) r_pre <= r_pre + PRE_W'(1);
      r_ext_q  <= ext_irq;
      r_status <= w_status_nxt;
      if (w_wr && (bus.addr == OFS_MASK)) r_mask <= bus.din & w_valid & 8'hF0;
      if (w_rd) r_dout <= w_rdata;
      r_irq <= |(r_status & (w_ie | r_mask));
    end
  end

  assign irq        = r_irq;
  assign tick_short = w_tick_short;
  assign bus.dout   = r_dout;

endmodule
